// File: rtl/ss_pkg.sv
// Shared types and constants for the systolic-array stream feeder.
// Holds the FSM encoding, buffer geometry and the idle-timeout limit.
package ss_pkg;

  localparam int MAX_ELEMS = 16;
  localparam int DATA_W    = 16;
  localparam int RES_W     = 40;
  localparam int TIMEOUT   = 1023;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 5;
  localparam int IDLE_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND_W  = 3'd1,
    S_SEND_X  = 3'd2,
    S_WAIT    = 3'd3,
    S_COLLECT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Index of the last element of an N*N matrix: 3 for 2x2, 15 for 4x4.
  function automatic logic [IDX_W-1:0] last_idx(input logic size);
    return size ? 4'd15 : 4'd3;
  endfunction

endpackage

// File: rtl/ss_regfile.sv
// 16-entry register file, synchronous write and combinational read.
// Contents are never reset.
module ss_regfile
  import ss_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [MAX_ELEMS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ss_feeder.sv
// Streams the W then X matrices toward the systolic array and collects the
// N*N result beats into a result buffer, with an idle timeout on collection.
module ss_feeder
  import ss_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              size,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  result_cnt,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [RES_W-1:0]  rd_data,
  output logic              ss_in_valid,
  output logic [DATA_W-1:0] ss_matrix,
  output logic              ss_matrix_size,
  input  logic              ss_out_valid,
  input  logic [RES_W-1:0]  ss_out_value
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                size_q, size_d;
  logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                tout_q, tout_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   mat_q, mat_d;
  logic                msize_q, msize_d;

  logic [DATA_W-1:0]   w_rdata, x_rdata;
  logic                in_collect;
  logic                host_we;
  logic                capture;

  assign in_collect = (state_q == S_WAIT) || (state_q == S_COLLECT);
  assign host_we    = wr_en && (state_q == S_IDLE);
  assign capture    = in_collect && ss_out_valid;

  ss_regfile #(.WIDTH(DATA_W)) u_w_buf (
    .clk_i   (clk),
    .we_i    (host_we && !wr_sel),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (idx_q),
    .rdata_o (w_rdata)
  );

  ss_regfile #(.WIDTH(DATA_W)) u_x_buf (
    .clk_i   (clk),
    .we_i    (host_we && wr_sel),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (idx_q),
    .rdata_o (x_rdata)
  );

  ss_regfile #(.WIDTH(RES_W)) u_res_buf (
    .clk_i   (clk),
    .we_i    (capture),
    .waddr_i (res_cnt_q[IDX_W-1:0]),
    .wdata_i (ss_out_value),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // idx_q is zero whenever the FSM is idle, so W[0] is already on the read
  // port in the cycle start is sampled.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    size_d    = size_q;
    res_cnt_d = res_cnt_q;
    idle_d    = idle_q;
    tout_d    = tout_q;
    msize_d   = msize_q;
    done_d    = 1'b0;
    vld_d     = 1'b0;
    mat_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          size_d    = size;
          msize_d   = size;
          res_cnt_d = '0;
          tout_d    = 1'b0;
          idle_d    = '0;
          idx_d     = 4'd1;
          vld_d     = 1'b1;
          mat_d     = w_rdata;
          state_d   = S_SEND_W;
        end
      end
      S_SEND_W: begin
        vld_d = 1'b1;
        mat_d = w_rdata;
        if (idx_q == last_idx(size_q)) begin
          idx_d   = '0;
          state_d = S_SEND_X;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_SEND_X: begin
        vld_d = 1'b1;
        mat_d = x_rdata;
        if (idx_q == last_idx(size_q)) begin
          idx_d   = '0;
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_WAIT, S_COLLECT: begin
        if (ss_out_valid) begin
          res_cnt_d = res_cnt_q + 5'd1;
          idle_d    = '0;
          state_d   = S_COLLECT;
          if (res_cnt_q == {1'b0, last_idx(size_q)}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idle_d = idle_q + 10'd1;
        end
      end
      S_DONE: begin
        idle_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      size_q    <= 1'b0;
      res_cnt_q <= '0;
      idle_q    <= '0;
      tout_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      mat_q     <= '0;
      msize_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      size_q    <= size_d;
      res_cnt_q <= res_cnt_d;
      idle_q    <= idle_d;
      tout_q    <= tout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      vld_q     <= vld_d;
      mat_q     <= mat_d;
      msize_q   <= msize_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_err    = tout_q;
  assign result_cnt     = res_cnt_q;
  assign ss_in_valid    = vld_q;
  assign ss_matrix      = mat_q;
  assign ss_matrix_size = msize_q;

endmodule
